port_receiver: RTL

Downstream consumer for one output port of the 4-port packet switch. It watches the port's newdata_len and data_out. When it has room for the whole packet it grants with a one-cycle proceed pulse, then captures the byte stream into a store-and-forward buffer. Only complete packets are exposed to a host-side pop interface. One instance is placed per switch port (ports 1..4).

---
 rtl/port_receiver.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/port_receiver.sv
// port_receiver: store-and-forward receiver for one switch output port; grants a packet
// only when it fits, exposes complete packets to the host. Optional macro: PORT_RX_STATS_EN.
module port_receiver #(
    parameter int DEPTH     = 64,
    parameter int PKT_SLOTS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  newdata_len,
    input  logic [7:0]  data_out,
    output logic        proceed,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_eop,
    output logic        pkt_avail,
    output logic [4:0]  pkt_len,
    output logic        busy
`ifdef PORT_RX_STATS_EN
    ,
    output logic [15:0] rx_pkt_count,
    output logic [23:0] rx_byte_count
`endif
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int SW  = $clog2(PKT_SLOTS);
    localparam int SWP = SW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        RECV   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [4:0]     cur_len_q, cur_len_d;
    logic [4:0]     cnt_q, cnt_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  cmt_ptr_q, cmt_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [SW:0]    lwr_q, lwr_d;
    logic [SW:0]    lrd_q, lrd_d;
    logic [4:0]     head_cnt_q, head_cnt_d;
    logic           proceed_q, proceed_d;
    logic           busy_q, busy_d;
    logic [7:0]     rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           rd_eop_q, rd_eop_d;
    logic           pkt_avail_q, pkt_avail_d;
    logic [4:0]     pkt_len_q, pkt_len_d;

    logic [7:0]     mem_q [DEPTH];
    logic [4:0]     len_mem_q [PKT_SLOTS];

    logic [PW-1:0]  used_s, free_s;
    logic [SW:0]    slots_s;
    logic           wr_en_s, push_s, pop_s, pop_last_s;

    // Uncommitted bytes count as used, so free space is measured against the write pointer.
    assign used_s  = wr_ptr_q - rd_ptr_q;
    assign free_s  = PW'(DEPTH) - used_s;
    assign slots_s = lwr_q - lrd_q;

    // Next-state logic for the capture FSM, the host pop path and the head-packet view
    always_comb begin
        state_d     = state_q;
        cur_len_d   = cur_len_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        cmt_ptr_d   = cmt_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        lwr_d       = lwr_q;
        lrd_d       = lrd_q;
        head_cnt_d  = head_cnt_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        rd_eop_d    = 1'b0;
        wr_en_s     = 1'b0;
        push_s      = 1'b0;
        pop_s       = rd_en && pkt_avail_q && (rd_ptr_q != cmt_ptr_q);
        pop_last_s  = pop_s && (head_cnt_q == (pkt_len_q - 5'd1));

        case (state_q)
            IDLE: begin
                if ((newdata_len != 5'd0) && (free_s >= PW'(newdata_len)) &&
                    (slots_s != SWP'(PKT_SLOTS))) begin
                    state_d   = GRANT;
                    cur_len_d = newdata_len;
                end else begin
                    state_d   = IDLE;
                end
            end
            GRANT: begin
                state_d = RECV;
                cnt_d   = 5'd0;
            end
            RECV: begin
                wr_en_s  = 1'b1;
                wr_ptr_d = wr_ptr_q + PW'(1);
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == (cur_len_q - 5'd1)) begin
                    state_d = COMMIT;
                end else begin
                    state_d = RECV;
                end
            end
            COMMIT: begin
                push_s    = 1'b1;
                cmt_ptr_d = wr_ptr_q;
                lwr_d     = lwr_q + SWP'(1);
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop_s) begin
            rd_ptr_d   = rd_ptr_q + PW'(1);
            rd_data_d  = mem_q[rd_ptr_q[AW-1:0]];
            rd_valid_d = 1'b1;
            rd_eop_d   = pop_last_s;
            if (pop_last_s) begin
                head_cnt_d = 5'd0;
                lrd_d      = lrd_q + SWP'(1);
            end else begin
                head_cnt_d = head_cnt_q + 5'd1;
            end
        end else begin
            rd_data_d  = rd_data_q;
        end

        proceed_d   = (state_d == GRANT);
        busy_d      = (state_d != IDLE);
        pkt_avail_d = (lwr_d != lrd_d);
        // A push into an empty length FIFO lands on the new head slot this same edge.
        if (lwr_d == lrd_d) begin
            pkt_len_d = 5'd0;
        end else if (push_s && (lrd_d == lwr_q)) begin
            pkt_len_d = cur_len_q;
        end else begin
            pkt_len_d = len_mem_q[lrd_d[SW-1:0]];
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_len_q   <= 5'd0;
            cnt_q       <= 5'd0;
            wr_ptr_q    <= '0;
            cmt_ptr_q   <= '0;
            rd_ptr_q    <= '0;
            lwr_q       <= '0;
            lrd_q       <= '0;
            head_cnt_q  <= 5'd0;
            proceed_q   <= 1'b0;
            busy_q      <= 1'b0;
            rd_data_q   <= 8'd0;
            rd_valid_q  <= 1'b0;
            rd_eop_q    <= 1'b0;
            pkt_avail_q <= 1'b0;
            pkt_len_q   <= 5'd0;
        end else begin
            state_q     <= state_d;
            cur_len_q   <= cur_len_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            cmt_ptr_q   <= cmt_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            lwr_q       <= lwr_d;
            lrd_q       <= lrd_d;
            head_cnt_q  <= head_cnt_d;
            proceed_q   <= proceed_d;
            busy_q      <= busy_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            rd_eop_q    <= rd_eop_d;
            pkt_avail_q <= pkt_avail_d;
            pkt_len_q   <= pkt_len_d;
        end
    end

    // Byte store; contents need no reset because only committed bytes are ever read
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_out;
        end
    end

    // Length FIFO storage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PKT_SLOTS; i++) begin
                len_mem_q[i] <= 5'd0;
            end
        end else if (push_s) begin
            len_mem_q[lwr_q[SW-1:0]] <= cur_len_q;
        end
    end

    assign proceed   = proceed_q;
    assign busy      = busy_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_eop    = rd_eop_q;
    assign pkt_avail = pkt_avail_q;
    assign pkt_len   = pkt_len_q;

`ifdef PORT_RX_STATS_EN
    logic [15:0] rx_pkt_count_q, rx_pkt_count_d;
    logic [23:0] rx_byte_count_q, rx_byte_count_d;
    logic [24:0] byte_sum_s;

    // Saturating packet and byte counters, stepped on each commit
    always_comb begin
        rx_pkt_count_d  = rx_pkt_count_q;
        rx_byte_count_d = rx_byte_count_q;
        byte_sum_s      = {1'b0, rx_byte_count_q} + {20'd0, cur_len_q};
        if (push_s) begin
            if (rx_pkt_count_q != 16'hFFFF) begin
                rx_pkt_count_d = rx_pkt_count_q + 16'd1;
            end else begin
                rx_pkt_count_d = rx_pkt_count_q;
            end
            if (byte_sum_s[24]) begin
                rx_byte_count_d = 24'hFF_FFFF;
            end else begin
                rx_byte_count_d = byte_sum_s[23:0];
            end
        end else begin
            rx_pkt_count_d  = rx_pkt_count_q;
            rx_byte_count_d = rx_byte_count_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_pkt_count_q  <= 16'd0;
            rx_byte_count_q <= 24'd0;
        end else begin
            rx_pkt_count_q  <= rx_pkt_count_d;
            rx_byte_count_q <= rx_byte_count_d;
        end
    end

    assign rx_pkt_count  = rx_pkt_count_q;
    assign rx_byte_count = rx_byte_count_q;
`endif

endmodule
